watch_time_core: RTL

Timekeeping core for the watch display path: generates the msec/sec/min/hour values and the per-field adjust highlight consumed by the seven-segment FND controller. It divides the system clock down to a 10 ms tick, runs a cascaded centisecond/second/minute/hour counter, and provides a button-driven adjust mode in which one field at a time is selected and stepped up or down. It sits directly upstream of the FND controller; its outputs connect to that block's `msec`, `sec`, `min`, `hour` and `adjust_digit_sel` inputs without any glue logic.

---
 rtl/watch_time_core.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/watch_time_core.sv
// watch_time_core
// Timekeeping core for the watch display path. Divides the system clock down
// to a 10 ms tick, runs a cascaded centisecond/second/minute/hour counter, and
// offers a button-driven adjust mode that steps one field at a time.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   btn_mode         pulse: toggle RUN / ADJUST
//   btn_sel          pulse: cycle adjusted field sec -> min -> hour -> sec
//   btn_up/btn_down  pulses: step selected field (both together = no change)
//   msec/sec/min/hour  registered time fields
//   adjust_digit_sel one-hot highlight {sec,min,hour,0}, zero in RUN
//   adjusting        high in any ADJUST state
module watch_time_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [3:0] adjust_digit_sel,
  output logic       adjusting
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ADJ_SEC  = 2'd1,
    ST_ADJ_MIN  = 2'd2,
    ST_ADJ_HOUR = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [6:0]      msec_q, msec_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hour_q, hour_d;
  logic [3:0]      sel_q, sel_d;
  logic            adjusting_q, adjusting_d;
  logic            tick_s;
  logic            step_en_s;

  // Modulo step of one field; never produces a carry out of the field.
  function automatic logic [5:0] step_wrap(input logic [5:0] val,
                                           input logic       up,
                                           input logic [5:0] last);
    logic [5:0] res;
    if (up) begin
      if (val == last) res = 6'd0;
      else             res = val + 6'd1;
    end else begin
      if (val == 6'd0) res = last;
      else             res = val - 6'd1;
    end
    return res;
  endfunction

  // The prescaler only runs in RUN, so the tick is qualified by state.
  assign tick_s    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  // Opposing up/down pulses cancel.
  assign step_en_s = btn_up ^ btn_down;

  // Next-state, counter cascade and adjust stepping.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    msec_d      = msec_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sel_d       = 4'b0000;
    adjusting_d = 1'b0;

    if (state_q == ST_RUN) begin
      // Time keeps advancing on the edge that also sees btn_mode.
      if (tick_s) begin
        presc_d = '0;
        if (msec_q == 7'd99) begin
          msec_d = 7'd0;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d = 6'd0;
              if (hour_q == 5'd23) hour_d = 5'd0;
              else                 hour_d = hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (btn_mode) state_d = ST_ADJ_SEC;
      else          state_d = ST_RUN;
    end else begin
      if (btn_mode) begin
        // Restart the sub-second phase so the first tick is a full DIV away.
        state_d = ST_RUN;
        presc_d = '0;
        msec_d  = 7'd0;
      end else if (btn_sel) begin
        case (state_q)
          ST_ADJ_SEC: state_d = ST_ADJ_MIN;
          ST_ADJ_MIN: state_d = ST_ADJ_HOUR;
          default:    state_d = ST_ADJ_SEC;
        endcase
      end else if (step_en_s) begin
        case (state_q)
          ST_ADJ_SEC:  sec_d  = step_wrap(sec_q, btn_up, 6'd59);
          ST_ADJ_MIN:  min_d  = step_wrap(min_q, btn_up, 6'd59);
          ST_ADJ_HOUR: hour_d = 5'(step_wrap({1'b0, hour_q}, btn_up, 6'd23));
          default:     state_d = ST_RUN;
        endcase
      end else begin
        state_d = state_q;
      end
    end

    // Highlight is decoded from the next state so it lines up with the fields.
    case (state_d)
      ST_ADJ_SEC:  begin sel_d = 4'b1000; adjusting_d = 1'b1; end
      ST_ADJ_MIN:  begin sel_d = 4'b0100; adjusting_d = 1'b1; end
      ST_ADJ_HOUR: begin sel_d = 4'b0010; adjusting_d = 1'b1; end
      default:     begin sel_d = 4'b0000; adjusting_d = 1'b0; end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      msec_q      <= 7'd0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'(INIT_HOUR);
      sel_q       <= 4'b0000;
      adjusting_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      msec_q      <= msec_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sel_q       <= sel_d;
      adjusting_q <= adjusting_d;
    end
  end

  assign msec             = msec_q;
  assign sec              = sec_q;
  assign min              = min_q;
  assign hour             = hour_q;
  assign adjust_digit_sel = sel_q;
  assign adjusting        = adjusting_q;

endmodule
